// File: rtl/rv32i_pkg.sv
// Shared RV32I branch encodings and the PC/branch controller state type.
package rv32i_pkg;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  localparam logic [31:0] PC_STEP = 32'd4;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_FLUSH = 2'd1,
    ST_TRAP  = 2'd2
  } pc_state_e;

endpackage

// File: rtl/branch_cond.sv
// Branch condition decode from funct3 and the comparator's eq/lt results.
module branch_cond
  import rv32i_pkg::*;
(
  input  logic [2:0] funct3,
  input  logic       eq,
  input  logic       lt,
  output logic       cond
);

  always_comb begin
    cond = 1'b0;
    case (funct3)
      F3_BEQ:           cond = eq;
      F3_BNE:           cond = ~eq;
      F3_BLT, F3_BLTU:  cond = lt;
      F3_BGE, F3_BGEU:  cond = ~lt;
      default:          cond = 1'b0;
    endcase
  end

endmodule

// File: rtl/pc_branch_ctrl.sv
// Fetch PC sequencing with branch/jump redirect, post-redirect flush window
// and misaligned-target trap.
//
//   state    | meaning
//   ST_RUN   | normal fetch, branch/jump resolution active
//   ST_FLUSH | counting down the kill window after a taken redirect
//   ST_TRAP  | misaligned target seen; PC frozen until trap_ack
module pc_branch_ctrl
  import rv32i_pkg::*;
#(
  parameter logic [31:0] RESET_VEC    = 32'h0000_0000,
  parameter logic [31:0] TRAP_VEC     = 32'h0000_0100,
  parameter int          FLUSH_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  input  logic        br_valid,
  input  logic        jal,
  input  logic        jalr,
  input  logic [2:0]  funct3,
  input  logic        eq,
  input  logic        lt,
  output logic        br_un,
  input  logic [31:0] ex_pc,
  input  logic [31:0] imm,
  input  logic [31:0] rs1,
  input  logic        trap_ack,
  output logic [31:0] pc,
  output logic        taken,
  output logic        flush,
  output logic        trap,
  output logic [31:0] trap_pc
);

  localparam logic [2:0] FLUSH_LOAD = 3'(FLUSH_CYCLES);

  pc_state_e   state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [2:0]  cnt_q, cnt_d;
  logic        flush_q, flush_d;
  logic        trap_q, trap_d;
  logic [31:0] trap_pc_q, trap_pc_d;

  logic        cond;
  logic [31:0] jalr_sum;
  logic [31:0] target;
  logic        misaligned;

  branch_cond u_branch_cond (
    .funct3 (funct3),
    .eq     (eq),
    .lt     (lt),
    .cond   (cond)
  );

  assign br_un = funct3[1];

  // jal and a conditional branch share the pc-relative target, so only jalr
  // needs to win the target mux.
  assign jalr_sum   = rs1 + imm;
  assign target     = jalr ? {jalr_sum[31:1], 1'b0} : (ex_pc + imm);
  assign misaligned = (target[1:0] != 2'b00);

  assign taken = (state_q == ST_RUN) & ~stall & (jalr | jal | (br_valid & cond));

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    cnt_d     = cnt_q;
    trap_pc_d = trap_pc_q;
    case (state_q)
      ST_RUN: begin
        if (taken) begin
          if (misaligned) begin
            state_d   = ST_TRAP;
            trap_pc_d = target;
          end else begin
            state_d = ST_FLUSH;
            pc_d    = target;
            cnt_d   = FLUSH_LOAD;
          end
        end else if (!stall) begin
          pc_d = pc_q + PC_STEP;
        end
      end
      ST_FLUSH: begin
        cnt_d = cnt_q - 3'd1;
        if (cnt_q == 3'd1) begin
          state_d = ST_RUN;
        end
        if (!stall) begin
          pc_d = pc_q + PC_STEP;
        end
      end
      ST_TRAP: begin
        if (trap_ack) begin
          state_d = ST_RUN;
          pc_d    = TRAP_VEC;
        end
      end
      default: begin
        state_d = ST_RUN;
      end
    endcase
    flush_d = (state_d == ST_FLUSH) || (state_d == ST_TRAP);
    trap_d  = (state_d == ST_TRAP);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= ST_RUN;
      pc_q      <= RESET_VEC;
      cnt_q     <= 3'd0;
      flush_q   <= 1'b0;
      trap_q    <= 1'b0;
      trap_pc_q <= 32'd0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      cnt_q     <= cnt_d;
      flush_q   <= flush_d;
      trap_q    <= trap_d;
      trap_pc_q <= trap_pc_d;
    end
  end

  assign pc      = pc_q;
  assign flush   = flush_q;
  assign trap    = trap_q;
  assign trap_pc = trap_pc_q;

endmodule

// File: tb/tb_pc_branch_ctrl.sv
// Directed-vector bench for pc_branch_ctrl with hand-computed expectations.
module tb_pc_branch_ctrl;

  logic        clk;
  logic        rst_n;
  logic        stall;
  logic        br_valid;
  logic        jal;
  logic        jalr;
  logic [2:0]  funct3;
  logic        eq;
  logic        lt;
  logic        br_un;
  logic [31:0] ex_pc;
  logic [31:0] imm;
  logic [31:0] rs1;
  logic        trap_ack;
  logic [31:0] pc;
  logic        taken;
  logic        flush;
  logic        trap;
  logic [31:0] trap_pc;

  int n_checks = 0;
  int n_fail   = 0;

  pc_branch_ctrl dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .stall    (stall),
    .br_valid (br_valid),
    .jal      (jal),
    .jalr     (jalr),
    .funct3   (funct3),
    .eq       (eq),
    .lt       (lt),
    .br_un    (br_un),
    .ex_pc    (ex_pc),
    .imm      (imm),
    .rs1      (rs1),
    .trap_ack (trap_ack),
    .pc       (pc),
    .taken    (taken),
    .flush    (flush),
    .trap     (trap),
    .trap_pc  (trap_pc)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    stall    = 1'b0;
    br_valid = 1'b0;
    jal      = 1'b0;
    jalr     = 1'b0;
    funct3   = 3'b000;
    eq       = 1'b0;
    lt       = 1'b0;
    ex_pc    = 32'd0;
    imm      = 32'd0;
    rs1      = 32'd0;
    trap_ack = 1'b0;
  endtask

  // funct3, eq, lt, expected taken (conditional branch, RUN, no stall)
  typedef struct {
    logic [2:0] f3;
    logic       e;
    logic       l;
    logic       exp_t;
  } cond_vec_t;

  cond_vec_t cond_tbl[8] = '{
    '{3'b000, 1'b0, 1'b0, 1'b0},
    '{3'b001, 1'b0, 1'b1, 1'b1},
    '{3'b001, 1'b1, 1'b0, 1'b0},
    '{3'b100, 1'b0, 1'b1, 1'b1},
    '{3'b101, 1'b0, 1'b1, 1'b0},
    '{3'b111, 1'b1, 1'b0, 1'b1},
    '{3'b010, 1'b1, 1'b1, 1'b0},
    '{3'b011, 1'b1, 1'b0, 1'b0}
  };

  initial begin
    idle_inputs();
    rst_n = 1'b0;
    step();
    step();
    chk("reset_pc", pc, 32'h0);
    chk("reset_flush", {31'd0, flush}, 32'd0);
    chk("reset_trap", {31'd0, trap}, 32'd0);
    chk("reset_trap_pc", trap_pc, 32'h0);

    rst_n = 1'b1;
    step(); chk("idle_pc1", pc, 32'h4);
    step(); chk("idle_pc2", pc, 32'h8);
    step(); chk("idle_pc3", pc, 32'hC);
    chk("idle_flush", {31'd0, flush}, 32'd0);

    // Condition decode, checked combinationally inside one RUN cycle.
    br_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      funct3 = cond_tbl[i].f3;
      eq     = cond_tbl[i].e;
      lt     = cond_tbl[i].l;
      #1;
      chk($sformatf("cond_%0d", i), {31'd0, taken}, {31'd0, cond_tbl[i].exp_t});
    end
    idle_inputs();
    step();
    chk("after_cond_pc", pc, 32'h10);

    // BEQ taken to 0x60, flush window of 2.
    br_valid = 1'b1; funct3 = 3'b000; eq = 1'b1; ex_pc = 32'h40; imm = 32'h20;
    #1;
    chk("beq_taken", {31'd0, taken}, 32'd1);
    chk("beq_br_un", {31'd0, br_un}, 32'd0);
    step();
    idle_inputs();
    chk("beq_pc", pc, 32'h60);
    chk("beq_flush1", {31'd0, flush}, 32'd1);
    jal = 1'b1; ex_pc = 32'h1000;
    #1;
    chk("flush_ignores_jal", {31'd0, taken}, 32'd0);
    step();
    jal = 1'b0;
    chk("beq_flush2", {31'd0, flush}, 32'd1);
    chk("beq_pc2", pc, 32'h64);
    step();
    chk("beq_flush_end", {31'd0, flush}, 32'd0);
    chk("beq_pc3", pc, 32'h68);

    // BLTU not taken, then stalled.
    br_valid = 1'b1; funct3 = 3'b110; lt = 1'b0;
    #1;
    chk("bltu_br_un", {31'd0, br_un}, 32'd1);
    chk("bltu_taken", {31'd0, taken}, 32'd0);
    step();
    chk("bltu_pc", pc, 32'h6C);
    stall = 1'b1; lt = 1'b1;
    #1;
    chk("stall_taken", {31'd0, taken}, 32'd0);
    step();
    chk("stall_pc", pc, 32'h6C);
    idle_inputs();

    // JALR to misaligned target 0x102.
    jalr = 1'b1; rs1 = 32'h101; imm = 32'h1;
    #1;
    chk("jalr_taken", {31'd0, taken}, 32'd1);
    step();
    idle_inputs();
    chk("trap_set", {31'd0, trap}, 32'd1);
    chk("trap_pc", trap_pc, 32'h102);
    chk("trap_pc_hold", pc, 32'h6C);
    chk("trap_flush", {31'd0, flush}, 32'd1);
    for (int i = 0; i < 3; i++) begin
      stall = (i == 1);
      jal   = (i == 2);
      ex_pc = 32'h200;
      step();
      chk($sformatf("trap_wait_pc%0d", i), pc, 32'h6C);
      chk($sformatf("trap_wait_trap%0d", i), {31'd0, trap}, 32'd1);
    end
    idle_inputs();
    trap_ack = 1'b1;
    step();
    trap_ack = 1'b0;
    chk("ack_pc", pc, 32'h100);
    chk("ack_trap", {31'd0, trap}, 32'd0);
    chk("ack_flush", {31'd0, flush}, 32'd0);
    chk("ack_trap_pc_held", trap_pc, 32'h102);

    trap_ack = 1'b1;
    step();
    trap_ack = 1'b0;
    chk("stray_ack_pc", pc, 32'h104);

    // jal beats br_valid; both pc-relative but rs1 must not leak in.
    jal = 1'b1; br_valid = 1'b1; funct3 = 3'b000; eq = 1'b1;
    ex_pc = 32'h80; imm = 32'h8; rs1 = 32'h200;
    step();
    idle_inputs();
    chk("jal_pc", pc, 32'h88);
    step(); step();
    chk("jal_post_pc", pc, 32'h90);

    // jalr beats jal.
    jalr = 1'b1; jal = 1'b1; ex_pc = 32'h80; imm = 32'h8; rs1 = 32'h200;
    step();
    idle_inputs();
    chk("jalr_prio_pc", pc, 32'h208);
    step(); step();
    chk("jalr_post_pc", pc, 32'h210);

    // Jump to 0xFFFF_FFFC, stall through flush (counter still runs), then wrap.
    jal = 1'b1; ex_pc = 32'hFFFF_FFF0; imm = 32'hC;
    step();
    idle_inputs();
    stall = 1'b1;
    step(); step();
    chk("stall_flush_pc", pc, 32'hFFFF_FFFC);
    chk("stall_flush_done", {31'd0, flush}, 32'd0);
    stall = 1'b0;
    step();
    chk("wrap_pc", pc, 32'h0);

    // Reset one edge after a taken branch.
    jal = 1'b1; ex_pc = 32'h40; imm = 32'h20;
    step();
    idle_inputs();
    chk("pre_rst_flush", {31'd0, flush}, 32'd1);
    rst_n = 1'b0;
    step();
    chk("mid_rst_pc", pc, 32'h0);
    chk("mid_rst_flush", {31'd0, flush}, 32'd0);
    rst_n = 1'b1;
    step();
    chk("post_rst_pc", pc, 32'h4);
    chk("post_rst_flush", {31'd0, flush}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
